sad_disp_search: RTL and testbench
==================================

# sad_disp_search

Parametrised, sequential SAD disparity-search engine. It is the successor to `compute_max_disp`. It takes one window band from the left image and one from the right, each WIN rows × IMG_W pixels. Over a configurable disparity range [MIN_DISP, MAX_DISP) it returns the best disparity, that disparity's SAD, and match-quality flags. It works with either image as the reference, computes one window column per cycle so latency is deterministic, and delivers the result through a valid/ready output handshake. It sits between the row-band buffer and the disparity-map writer.

## Interface
- WIN, 15, window side in pixels (odd, ≥3)
- DATA_SIZE, 8, bits per pixel
- IMG_W, 64, band width in pixels (≥ WIN)
- MIN_DISP, 0, smallest candidate disparity (inclusive)
- MAX_DISP, 64, disparity bound (exclusive); NUM_DISP = MAX_DISP−MIN_DISP ≥ 1
- UNIQ_THRESH, 16, SAD margin for the uniqueness check (used only with SAD_UNIQ_EN)
- Derived: SAD_BITS = $clog2(WIN*WIN*(2^DATA_SIZE−1)+1); DISP_BITS = $clog2(MAX_DISP); COL_BITS = $clog2(IMG_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- input_array_L  in  DATA_SIZE*IMG_W*WIN  left band; pixel (row r, col x) at index r*IMG_W+x
- input_array_R  in  DATA_SIZE*IMG_W*WIN  right band, same packing
- col_index  in  COL_BITS  left column of the reference window
- ref_right  in  1  0: left image is the reference; 1: right image is the reference
- start  in  1  request; accepted only in IDLE
- busy  out  1  high in RUN and DONE
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts the result
- out_disp  out  DISP_BITS  best disparity
- out_sad  out  SAD_BITS  SAD of out_disp
- no_match  out  1  no candidate was in range
- ambiguous  out  1  uniqueness failure (0 when SAD_UNIQ_EN is not defined)

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE:
  - When start=1, register both bands, col_index and ref_right.
  - Set d=MIN_DISP, c=0, acc=0, best_sad=all-ones, found=0.
  - Next state is RUN.
- RUN, each cycle:
  - acc += Σ over r=0..WIN−1 of |ref(r, col+c) − cand(r, x+c)|.
  - In left-reference mode, ref is L and x = col−d.
  - In right-reference mode, ref is R and x = col+d.
  - Absolute differences are unsigned, DATA_SIZE bits wide. Sums use SAD_BITS and cannot overflow.
- Candidate validity:
  - Left-reference mode: the candidate is valid iff col ≥ d.
  - Right-reference mode: the candidate is valid iff col+d+WIN ≤ IMG_W.
  - If col+WIN > IMG_W, every candidate is invalid.
  - An invalid candidate still takes WIN cycles. Its SAD is discarded, and indexing must never leave the band.
- At c=WIN−1, compare the final SAD (including this column) with best_sad:
  - Update on strict less-than only, so the lower disparity wins a tie.
  - Set found=1, clear acc, then advance d.
  - After d=MAX_DISP−1, go to DONE.
- DONE:
  - out_valid=1. Outputs are stable until the cycle where out_ready=1, then the block returns to IDLE.
  - If found=0: out_disp=0, out_sad=all-ones, no_match=1.
- start is ignored in RUN and DONE. It is not queued.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; busy, out_valid, out_disp, out_sad, no_match and ambiguous are all 0.
- start sampled high at edge T0: busy=1 after T0.
- RUN lasts NUM_DISP*WIN cycles. out_valid rises after edge T0+NUM_DISP*WIN.
- out_valid and out_ready both high at edge Tk: out_valid and busy fall after Tk. A new start can be accepted at edge Tk+1 at the earliest.
- Reset asserted mid-RUN or in DONE: the block aborts immediately, the result is lost, and all outputs go to their reset values.
- Input ports are sampled only at the accepting edge. Changing them during RUN has no effect.

## Configuration
- `SAD_UNIQ_EN` defined:
  - The block also tracks second_sad, the lowest valid SAD of any candidate other than the winner.
  - When a new best is found, the previous best becomes second_sad.
  - ambiguous=1 in DONE iff at least two valid candidates exist and second_sad − best_sad < UNIQ_THRESH.
- `SAD_UNIQ_EN` not defined: there is no second-best logic and ambiguous is tied to 0.

## Test plan
- Left-reference mode, random L, R = L shifted left by 5, col_index=20 → out_disp=5, out_sad=0, no_match=0; out_valid 960 cycles after start (defaults).
- Two candidates tie (uniform images, equal SAD), MIN_DISP=3 → out_disp=3 (lowest wins).
- Left-reference mode, col_index=2, true shift 10 → candidates d>2 skipped; result is chosen from d≤2 only. Then col_index=60 (>IMG_W−WIN) → no_match=1, out_disp=0, out_sad=all-ones.
- Right-reference mode, R random, L = R shifted right by 7, col_index=10 → out_disp=7, out_sad=0.
- out_ready held low for 50 cycles after out_valid → outputs unchanged and a start pulse is ignored. out_ready=1 → next cycle busy=0. Reset pulse mid-RUN → all outputs 0 immediately, then a fresh run completes correctly.
- With SAD_UNIQ_EN defined, constant-valued images → ambiguous=1. Shifted textured images → ambiguous=0. Without SAD_UNIQ_EN → ambiguous=0 always.

Source files
------------

// File: rtl/sad_disp_search_if.sv
// Band data, request and result handshake bundle for sad_disp_search.
interface sad_disp_search_if #(
    parameter int WIN       = 15,
    parameter int DATA_SIZE = 8,
    parameter int IMG_W     = 64,
    parameter int MAX_DISP  = 64
);
    localparam int SAD_BITS  = $clog2(WIN*WIN*((1 << DATA_SIZE) - 1) + 1);
    localparam int DISP_BITS = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;
    localparam int COL_BITS  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int BAND_BITS = DATA_SIZE*IMG_W*WIN;

    logic [BAND_BITS-1:0] input_array_L;
    logic [BAND_BITS-1:0] input_array_R;
    logic [COL_BITS-1:0]  col_index;
    logic                 ref_right;
    logic                 start;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [DISP_BITS-1:0] out_disp;
    logic [SAD_BITS-1:0]  out_sad;
    logic                 no_match;
    logic                 ambiguous;

    modport master (
        output input_array_L, input_array_R, col_index, ref_right, start, out_ready,
        input  busy, out_valid, out_disp, out_sad, no_match, ambiguous
    );

    modport slave (
        input  input_array_L, input_array_R, col_index, ref_right, start, out_ready,
        output busy, out_valid, out_disp, out_sad, no_match, ambiguous
    );
endinterface

// File: rtl/sad_disp_search.sv
// Sequential SAD disparity search, one window column per cycle over [MIN_DISP, MAX_DISP).
// Defining SAD_UNIQ_EN adds second-best tracking and drives the ambiguous flag.
//
// state | meaning
// IDLE  | waiting for start; bands captured on acceptance
// RUN   | accumulating one window column per cycle per candidate
// DONE  | result held on the outputs until out_ready
module sad_disp_search #(
    parameter int WIN         = 15,
    parameter int DATA_SIZE   = 8,
    parameter int IMG_W       = 64,
    parameter int MIN_DISP    = 0,
    parameter int MAX_DISP    = 64,
    parameter int UNIQ_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    sad_disp_search_if.slave bus
);
    localparam int SAD_BITS  = $clog2(WIN*WIN*((1 << DATA_SIZE) - 1) + 1);
    localparam int DISP_BITS = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1;
    localparam int COL_BITS  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int BAND_BITS = DATA_SIZE*IMG_W*WIN;
    localparam int BIDX      = $clog2(BAND_BITS);
    localparam int IW        = $clog2(IMG_W + MAX_DISP + WIN + 1) + 1;
    localparam int CNT_BITS  = $clog2(WIN);

    if ((WIN % 2 == 0) || (WIN < 3) || (IMG_W < WIN) || (MIN_DISP < 0) ||
        (MAX_DISP <= MIN_DISP) || (UNIQ_THRESH < 0)) begin : g_bad_params
        $error("sad_disp_search: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state;
    logic [BAND_BITS-1:0] r_band_l;
    logic [BAND_BITS-1:0] r_band_r;
    logic [COL_BITS-1:0]  r_col;
    logic                 r_ref_right;
    logic [DISP_BITS-1:0] r_d;
    logic [CNT_BITS-1:0]  r_cnt;
    logic [SAD_BITS-1:0]  r_acc;
    logic [SAD_BITS-1:0]  r_best_sad;
    logic [DISP_BITS-1:0] r_best_disp;
    logic                 r_found;
    logic                 r_busy;
    logic                 r_out_valid;
    logic [DISP_BITS-1:0] r_out_disp;
    logic [SAD_BITS-1:0]  r_out_sad;
    logic                 r_no_match;

    logic [IW-1:0]        w_col;
    logic [IW-1:0]        w_d;
    logic [IW-1:0]        w_off;
    logic                 w_valid;
    logic [IW-1:0]        w_ref_x;
    logic [IW-1:0]        w_cand_x;
    logic [BAND_BITS-1:0] w_ref_band;
    logic [BAND_BITS-1:0] w_cand_band;
    logic [DATA_SIZE-1:0] w_pa;
    logic [DATA_SIZE-1:0] w_pb;
    logic [DATA_SIZE-1:0] w_diff;
    logic [SAD_BITS-1:0]  w_col_sum;
    logic [SAD_BITS-1:0]  w_sad_final;
    logic                 w_take;
    logic [SAD_BITS-1:0]  w_best_sad_n;
    logic [DISP_BITS-1:0] w_best_disp_n;
    logic                 w_found_n;
    logic                 w_last_disp;

    function automatic logic [DATA_SIZE-1:0] pix(input logic [BAND_BITS-1:0] band,
                                                 input int r, input logic [IW-1:0] x);
        logic [BIDX-1:0] idx;
        idx = BIDX'((r*IMG_W + int'(x)) * DATA_SIZE);
        return band[idx +: DATA_SIZE];
    endfunction

    assign w_col   = IW'(r_col);
    assign w_d     = IW'(r_d);
    assign w_off   = IW'(WIN - 1) - IW'(r_cnt);
    assign w_valid = (w_col + IW'(WIN) <= IW'(IMG_W)) &&
                     (r_ref_right ? (w_col + w_d + IW'(WIN) <= IW'(IMG_W)) : (w_col >= w_d));

    // Invalid candidates read from column 0 so the band is never over-indexed.
    assign w_ref_x     = w_valid ? (w_col + w_off) : w_off;
    assign w_cand_x    = !w_valid ? w_off :
                         (r_ref_right ? (w_col + w_d + w_off) : (w_col - w_d + w_off));
    assign w_ref_band  = r_ref_right ? r_band_r : r_band_l;
    assign w_cand_band = r_ref_right ? r_band_l : r_band_r;

    always_comb begin
        w_col_sum = '0;
        w_pa      = '0;
        w_pb      = '0;
        w_diff    = '0;
        for (int r = 0; r < WIN; r++) begin
            w_pa      = pix(w_ref_band, r, w_ref_x);
            w_pb      = pix(w_cand_band, r, w_cand_x);
            w_diff    = (w_pa > w_pb) ? (w_pa - w_pb) : (w_pb - w_pa);
            w_col_sum = w_col_sum + SAD_BITS'(w_diff);
        end
    end

    assign w_sad_final   = r_acc + w_col_sum;
    assign w_take        = w_valid && (!r_found || (w_sad_final < r_best_sad));
    assign w_best_sad_n  = w_take ? w_sad_final : r_best_sad;
    assign w_best_disp_n = w_take ? r_d : r_best_disp;
    assign w_found_n     = r_found | w_valid;
    assign w_last_disp   = (r_d == DISP_BITS'(MAX_DISP - 1));

`ifdef SAD_UNIQ_EN
    logic [SAD_BITS-1:0] r_second_sad;
    logic [1:0]          r_nvalid;
    logic                r_ambiguous;
    logic [SAD_BITS-1:0] w_second_n;
    logic [1:0]          w_nvalid_n;
    logic                w_ambig_n;

    always_comb begin
        w_second_n = r_second_sad;
        if (w_valid) begin
            if (w_take) begin
                if (r_found) w_second_n = r_best_sad;
            end else if ((r_nvalid < 2'd2) || (w_sad_final < r_second_sad)) begin
                w_second_n = w_sad_final;
            end
        end
    end

    assign w_nvalid_n = (w_valid && (r_nvalid != 2'd2)) ? (r_nvalid + 2'd1) : r_nvalid;
    assign w_ambig_n  = (w_nvalid_n == 2'd2) &&
                        (int'(w_second_n - w_best_sad_n) < UNIQ_THRESH);
    assign bus.ambiguous = r_ambiguous;
`else
    assign bus.ambiguous = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_band_l    <= '0;
            r_band_r    <= '0;
            r_col       <= '0;
            r_ref_right <= 1'b0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_best_sad  <= '1;
            r_best_disp <= '0;
            r_found     <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_disp  <= '0;
            r_out_sad   <= '0;
            r_no_match  <= 1'b0;
`ifdef SAD_UNIQ_EN
            r_second_sad <= '1;
            r_nvalid     <= '0;
            r_ambiguous  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_band_l    <= bus.input_array_L;
                        r_band_r    <= bus.input_array_R;
                        r_col       <= bus.col_index;
                        r_ref_right <= bus.ref_right;
                        r_d         <= DISP_BITS'(MIN_DISP);
                        r_cnt       <= CNT_BITS'(WIN - 1);
                        r_acc       <= '0;
                        r_best_sad  <= '1;
                        r_best_disp <= '0;
                        r_found     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
`ifdef SAD_UNIQ_EN
                        r_second_sad <= '1;
                        r_nvalid     <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                        r_acc <= w_sad_final;
                    end else begin
                        r_cnt       <= CNT_BITS'(WIN - 1);
                        r_acc       <= '0;
                        r_best_sad  <= w_best_sad_n;
                        r_best_disp <= w_best_disp_n;
                        r_found     <= w_found_n;
                        r_d         <= r_d + 1'b1;
`ifdef SAD_UNIQ_EN
                        r_second_sad <= w_second_n;
                        r_nvalid     <= w_nvalid_n;
`endif
                        if (w_last_disp) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out_disp  <= w_found_n ? w_best_disp_n : '0;
                            r_out_sad   <= w_found_n ? w_best_sad_n : '1;
                            r_no_match  <= !w_found_n;
`ifdef SAD_UNIQ_EN
                            r_ambiguous <= w_ambig_n;
`endif
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_disp  = r_out_disp;
    assign bus.out_sad   = r_out_sad;
    assign bus.no_match  = r_no_match;
endmodule

// File: tb/tb_sad_disp_search.sv
// Scoreboard bench for sad_disp_search: directed bands, expected results queued at start.
module tb_sad_disp_search;
    localparam int WIN         = 15;
    localparam int DATA_SIZE   = 8;
    localparam int IMG_W       = 64;
    localparam int MIN_DISP    = 0;
    localparam int MAX_DISP    = 64;
    localparam int UNIQ_THRESH = 16;
    localparam int NUM_DISP    = MAX_DISP - MIN_DISP;
    localparam int SAD_BITS    = $clog2(WIN*WIN*((1 << DATA_SIZE) - 1) + 1);
    localparam int DISP_BITS   = $clog2(MAX_DISP);
    localparam int COL_BITS    = $clog2(IMG_W);
    localparam int BAND_BITS   = DATA_SIZE*IMG_W*WIN;
`ifdef SAD_UNIQ_EN
    localparam bit UNIQ = 1'b1;
`else
    localparam bit UNIQ = 1'b0;
`endif

    typedef struct {
        int                   id;
        logic [DISP_BITS-1:0] disp;
        logic [SAD_BITS-1:0]  sad;
        logic                 nm;
        logic                 amb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sad_disp_search_if #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP)) ifc ();

    sad_disp_search #(
        .WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W),
        .MIN_DISP(MIN_DISP), .MAX_DISP(MAX_DISP), .UNIQ_THRESH(UNIQ_THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    exp_t                 sb_q[$];
    int                   checks   = 0;
    int                   failures = 0;
    longint               cyc      = 0;
    logic [BAND_BITS-1:0] band_l;
    logic [BAND_BITS-1:0] band_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: the result is consumed on an edge where out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (rst && ifc.out_valid && ifc.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("run%0d_disp", e.id), ifc.out_disp, e.disp);
                check($sformatf("run%0d_sad", e.id), ifc.out_sad, e.sad);
                check($sformatf("run%0d_no_match", e.id), ifc.no_match, e.nm);
                check($sformatf("run%0d_ambiguous", e.id), ifc.ambiguous, e.amb);
            end
        end
    end

    function automatic logic [DATA_SIZE-1:0] getp(input logic [BAND_BITS-1:0] b, input int r, input int x);
        return b[(r*IMG_W + x)*DATA_SIZE +: DATA_SIZE];
    endfunction

    task automatic fill_left_ref(input int shift);
        for (int r = 0; r < WIN; r++)
            for (int x = 0; x < IMG_W; x++)
                band_l[(r*IMG_W + x)*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'($urandom);
        for (int r = 0; r < WIN; r++)
            for (int x = 0; x < IMG_W; x++)
                band_r[(r*IMG_W + x)*DATA_SIZE +: DATA_SIZE] =
                    (x + shift < IMG_W) ? getp(band_l, r, x + shift) : DATA_SIZE'($urandom);
    endtask

    task automatic fill_right_ref(input int shift);
        for (int r = 0; r < WIN; r++)
            for (int x = 0; x < IMG_W; x++)
                band_r[(r*IMG_W + x)*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'($urandom);
        for (int r = 0; r < WIN; r++)
            for (int x = 0; x < IMG_W; x++)
                band_l[(r*IMG_W + x)*DATA_SIZE +: DATA_SIZE] =
                    (x >= shift) ? getp(band_r, r, x - shift) : DATA_SIZE'($urandom);
    endtask

    task automatic fill_uniform(input logic [DATA_SIZE-1:0] lv, input logic [DATA_SIZE-1:0] rv);
        for (int i = 0; i < IMG_W*WIN; i++) begin
            band_l[i*DATA_SIZE +: DATA_SIZE] = lv;
            band_r[i*DATA_SIZE +: DATA_SIZE] = rv;
        end
    endtask

    function automatic int model_sad(input bit rr, input int col, input int d);
        int s, a, b, x;
        s = 0;
        x = rr ? col + d : col - d;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++) begin
                a = rr ? int'(getp(band_r, r, col + c)) : int'(getp(band_l, r, col + c));
                b = rr ? int'(getp(band_l, r, x + c)) : int'(getp(band_r, r, x + c));
                s += (a > b) ? a - b : b - a;
            end
        return s;
    endfunction

    // Reference result: exhaustive two-pass search (winner first, then runner-up).
    function automatic exp_t model_expect(input int id, input bit rr, input int col);
        exp_t e;
        int   sads[MAX_DISP];
        bit   val[MAX_DISP];
        int   bd, bs, ss, nv;
        bd = -1; bs = 0; ss = -1; nv = 0;
        for (int d = 0; d < MAX_DISP; d++) begin
            val[d]  = (d >= MIN_DISP) && (col + WIN <= IMG_W) &&
                      (rr ? (col + d + WIN <= IMG_W) : (col >= d));
            sads[d] = val[d] ? model_sad(rr, col, d) : 0;
            if (val[d]) begin
                nv++;
                if (bd < 0 || sads[d] < bs) begin bd = d; bs = sads[d]; end
            end
        end
        for (int d = 0; d < MAX_DISP; d++)
            if (val[d] && d != bd && (ss < 0 || sads[d] < ss)) ss = sads[d];
        e.id = id;
        if (bd < 0) begin
            e.disp = '0; e.sad = '1; e.nm = 1'b1; e.amb = 1'b0;
        end else begin
            e.disp = DISP_BITS'(bd);
            e.sad  = SAD_BITS'(bs);
            e.nm   = 1'b0;
            e.amb  = UNIQ && (nv >= 2) && ((ss - bs) < UNIQ_THRESH);
        end
        return e;
    endfunction

    function automatic exp_t mk(input int id, input int disp, input int sad, input bit nm, input bit amb);
        exp_t e;
        e.id = id; e.disp = DISP_BITS'(disp); e.sad = SAD_BITS'(sad); e.nm = nm; e.amb = amb;
        return e;
    endfunction

    task automatic launch(input int col, input bit rr, input string tag);
        ifc.input_array_L = band_l;
        ifc.input_array_R = band_r;
        ifc.col_index     = COL_BITS'(col);
        ifc.ref_right     = rr;
        ifc.start         = 1'b1;
        tick();
        ifc.start = 1'b0;
        check({tag, "_busy_after_start"}, ifc.busy, 1);
    endtask

    task automatic wait_result(input string tag, input longint t0);
        int n;
        n = 0;
        while (!ifc.out_valid && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, cyc - t0, NUM_DISP*WIN);
    endtask

    task automatic full_run(input exp_t e, input int col, input bit rr, input string tag);
        longint t0;
        sb_q.push_back(e);
        launch(col, rr, tag);
        t0 = cyc;
        wait_result(tag, t0);
        tick();
        check({tag, "_valid_cleared"}, ifc.out_valid, 0);
        check({tag, "_busy_cleared"}, ifc.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t   e;
        longint t0;
        bit     stable;
        bit     idle_ok;

        ifc.input_array_L = '0;
        ifc.input_array_R = '0;
        ifc.col_index     = '0;
        ifc.ref_right     = 1'b0;
        ifc.start         = 1'b0;
        ifc.out_ready     = 1'b1;
        repeat (3) tick();
        check("reset_busy", ifc.busy, 0);
        check("reset_valid", ifc.out_valid, 0);
        check("reset_disp", ifc.out_disp, 0);
        check("reset_sad", ifc.out_sad, 0);
        check("reset_no_match", ifc.no_match, 0);
        check("reset_ambiguous", ifc.ambiguous, 0);
        rst = 1'b1;
        tick();

        fill_left_ref(5);
        full_run(mk(1, 5, 0, 1'b0, 1'b0), 20, 1'b0, "lshift5");

        // Uniform bands: every valid candidate costs 225*10; lowest disparity wins.
        fill_uniform(8'd100, 8'd90);
        full_run(mk(2, 0, 2250, 1'b0, UNIQ), 20, 1'b0, "tie");

        fill_left_ref(10);
        full_run(model_expect(3, 1'b0, 2), 2, 1'b0, "col2");

        full_run(mk(4, 0, (1 << SAD_BITS) - 1, 1'b1, 1'b0), 60, 1'b0, "col60");

        // Right reference with the consumer stalling for 50 cycles.
        fill_right_ref(7);
        ifc.out_ready = 1'b0;
        e = mk(5, 7, 0, 1'b0, 1'b0);
        sb_q.push_back(e);
        launch(10, 1'b1, "rshift7");
        t0 = cyc;
        wait_result("rshift7", t0);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            ifc.start = (i == 20);
            if (!(ifc.out_valid && ifc.busy && ifc.out_disp == e.disp && ifc.out_sad == e.sad &&
                  !ifc.no_match))
                stable = 1'b0;
            tick();
        end
        ifc.start = 1'b0;
        check("hold_outputs_stable", stable, 1);
        ifc.out_ready = 1'b1;
        tick();
        check("hold_valid_cleared", ifc.out_valid, 0);
        check("hold_busy_cleared", ifc.busy, 0);
        idle_ok = 1'b1;
        repeat (5) begin
            tick();
            if (ifc.busy) idle_ok = 1'b0;
        end
        check("start_in_done_not_queued", idle_ok, 1);

        // Abort mid-run; outputs must clear without waiting for a clock edge.
        fill_left_ref(5);
        launch(20, 1'b0, "abort");
        repeat (100) tick();
        rst = 1'b0;
        #1;
        check("abort_busy", ifc.busy, 0);
        check("abort_valid", ifc.out_valid, 0);
        check("abort_disp", ifc.out_disp, 0);
        check("abort_sad", ifc.out_sad, 0);
        check("abort_no_match", ifc.no_match, 0);
        check("abort_ambiguous", ifc.ambiguous, 0);
        tick();
        rst = 1'b1;
        tick();

        fill_left_ref(3);
        full_run(mk(6, 3, 0, 1'b0, 1'b0), 30, 1'b0, "after_abort");

        repeat (3) tick();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
